// File: rtl/br_misc_pkg.sv
// Shared types and parameter limits for the br_misc sink blocks.
package br_misc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  localparam int unsigned MinRequesters  = 2;
  localparam int unsigned MinWidth       = 1;
  localparam int unsigned MinCountWidth  = 1;
  localparam int unsigned MinQuietCycles = 1;

endpackage

// File: rtl/br_misc_sink_arb_rr.sv
// Round-robin grant over valid bits with a registered priority pointer.
module br_misc_sink_arb_rr #(
  parameter int unsigned NumRequesters = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic [NumRequesters-1:0] valid_i,
  output logic [NumRequesters-1:0] grant_o
);

  localparam int unsigned PtrWidth = $clog2(NumRequesters);

  logic [PtrWidth-1:0] ptr_q, ptr_d;
  logic [PtrWidth-1:0] idx_hi, idx_lo, grant_idx;
  logic                hit_hi, hit_lo, found;

  // Wrap-around search split into "at/after pointer" and "before pointer" halves.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int unsigned i = 0; i < NumRequesters; i++) begin
      if (valid_i[i]) begin
        if (i >= 32'(ptr_q)) begin
          if (!hit_hi) begin
            hit_hi = 1'b1;
            idx_hi = PtrWidth'(i);
          end
        end else if (!hit_lo) begin
          hit_lo = 1'b1;
          idx_lo = PtrWidth'(i);
        end
      end
    end
    found     = hit_hi | hit_lo;
    grant_idx = hit_hi ? idx_hi : idx_lo;

    grant_o = '0;
    ptr_d   = ptr_q;
    if (en_i && found) begin
      grant_o[grant_idx] = 1'b1;
      ptr_d = (grant_idx == PtrWidth'(NumRequesters - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/br_misc_unused.sv
// Terminates a bus that is intentionally left unconsumed.
module br_misc_unused #(
  parameter int unsigned Width = 1
) (
  input logic [Width-1:0] in_i
);

  logic unused_reduce;
  assign unused_reduce = ^in_i;

endmodule

// File: rtl/br_misc_sink_arb.sv
// Round-robin discard sink with saturating drop counter and quiet-based drain sequencer.
module br_misc_sink_arb
  import br_misc_pkg::*;
#(
  parameter int unsigned NumRequesters = 2,
  parameter int unsigned Width         = 1,
  parameter int unsigned CountWidth    = 16,
  parameter int unsigned QuietCycles   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NumRequesters-1:0]       in_valid,
  output logic [NumRequesters-1:0]       in_ready,
  input  logic [NumRequesters*Width-1:0] in_data,
  input  logic                           drain_start,
  output logic                           drain_busy,
  output logic                           drain_done,
  input  logic                           count_clear,
  output logic [CountWidth-1:0]          drop_count
);

  if (NumRequesters < MinRequesters) begin : g_bad_requesters
    $error("br_misc_sink_arb: NumRequesters must be at least 2");
  end
  if (Width < MinWidth) begin : g_bad_width
    $error("br_misc_sink_arb: Width must be at least 1");
  end
  if (CountWidth < MinCountWidth) begin : g_bad_count_width
    $error("br_misc_sink_arb: CountWidth must be at least 1");
  end
  if (QuietCycles < MinQuietCycles) begin : g_bad_quiet
    $error("br_misc_sink_arb: QuietCycles must be at least 1");
  end

  localparam int unsigned QcWidth = $clog2(QuietCycles + 1);

  drain_state_t          state_q, state_d;
  logic [QcWidth-1:0]    quiet_q, quiet_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  accept_en;
  logic                  xfer;

  // rst_n gates acceptance so in_ready drops the instant reset asserts.
  assign accept_en = rst_n & ((state_q != IDLE) | enable);

  br_misc_sink_arb_rr #(
    .NumRequesters(NumRequesters)
  ) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (accept_en),
    .valid_i(in_valid),
    .grant_o(in_ready)
  );

  br_misc_unused #(
    .Width(NumRequesters * Width)
  ) u_unused (
    .in_i(in_data)
  );

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    state_d = state_q;
    quiet_d = quiet_q;
    unique case (state_q)
      IDLE: begin
        if (drain_start) begin
          state_d = DRAIN;
          quiet_d = '0;
        end
      end
      DRAIN: begin
        if (|in_valid) begin
          quiet_d = '0;
        end else if (quiet_q != QcWidth'(QuietCycles)) begin
          quiet_d = quiet_q + 1'b1;
        end
        if (quiet_d == QcWidth'(QuietCycles)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (count_clear) begin
      count_d = xfer ? CountWidth'(1) : '0;
    end else if (xfer && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quiet_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      count_q <= count_d;
    end
  end

  assign drain_busy = (state_q == DRAIN);
  assign drain_done = (state_q == DONE);
  assign drop_count = count_q;

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

  a_done_single : assert property (@(posedge clk) disable iff (!rst_n) drain_done |=> !drain_done);

  for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_valid_hold
    a_valid_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid[gi] && !in_ready[gi]) |=>
        (in_valid[gi] && $stable(in_data[gi*Width +: Width])));
  end

endmodule

// File: tb/tb_br_misc_sink_arb.sv
// Directed plus randomized bench for br_misc_sink_arb against a cycle-level reference model.
module tb_br_misc_sink_arb;

  localparam int N    = 3;
  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int Q    = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  in_data = '0;
  logic            drain_start = 1'b0;
  logic            drain_busy;
  logic            drain_done;
  logic            count_clear = 1'b0;
  logic [CW-1:0]   drop_count;

  always #5 clk = ~clk;

  br_misc_sink_arb #(
    .NumRequesters(N),
    .Width        (W),
    .CountWidth   (CW),
    .QuietCycles  (Q)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .drain_start(drain_start),
    .drain_busy (drain_busy),
    .drain_done (drain_done),
    .count_clear(count_clear),
    .drop_count (drop_count)
  );

  int checks = 0;
  int errors = 0;

  // Source side: each source keeps a pending item until it is accepted.
  logic [N-1:0] pend = '0;
  logic [W-1:0] dat [N];
  logic [N-1:0] last_ready;

  // Reference model: plain phase flags, pointer and counts.
  int m_ptr   = 0;
  int m_count = 0;
  int m_quiet = 0;
  bit m_drain = 0;
  bit m_done  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_count = 0; m_quiet = 0; m_drain = 0; m_done = 0;
  endtask

  function automatic int model_grant();
    bit active;
    active = m_drain || m_done || enable;
    if (!active) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input int g);
    bit x;
    x = (g >= 0);
    if (count_clear) m_count = x ? 1 : 0;
    else if (x && m_count < CMAX) m_count++;
    if (x) m_ptr = (g + 1) % N;
    if (m_done) begin
      m_done = 0;
    end else if (m_drain) begin
      if (in_valid != '0) m_quiet = 0;
      else if (m_quiet < Q) m_quiet++;
      if (m_quiet >= Q) begin
        m_drain = 0;
        m_done  = 1;
      end
    end else if (drain_start) begin
      m_drain = 1;
      m_quiet = 0;
    end
  endtask

  task automatic raise(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !pend[i]) begin
        pend[i] = 1'b1;
        dat[i]  = W'($urandom);
      end
    end
  endtask

  task automatic apply_inputs();
    in_valid = pend;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
  endtask

  // Called at a falling edge; ends at the next falling edge.
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    apply_inputs();
    #1;
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    last_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    model_step(g);
    if (g >= 0) pend[g] = 1'b0;
    #1;
    chk("drain_busy", 32'(drain_busy), 32'(m_drain));
    chk("drain_done", 32'(drain_done), 32'(m_done));
    chk("drop_count", 32'(drop_count), 32'(m_count));
    drain_start = 1'b0;
    count_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic flush();
    int guard;
    guard = 0;
    while (pend != '0 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("flush_bound", 32'(pend), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) dat[i] = '0;

    // Reset state, with valids asserted to show in_ready is held low.
    in_valid = '1;
    enable   = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 32'(0));
    chk("rst_busy", 32'(drain_busy), 32'(0));
    chk("rst_done", 32'(drain_done), 32'(0));
    chk("rst_count", 32'(drop_count), 32'(0));
    in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all sources continuously requesting.
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] eg;
      raise('1);
      cycle();
      eg = '0;
      eg[k % N] = 1'b1;
      chk("fair_grant", 32'(last_ready), 32'(eg));
    end
    chk("fair_count", 32'(drop_count), 32'(CMAX < 6 ? CMAX : 6));
    flush();
    count_clear = 1'b1;
    cycle();

    // Gating: enable low blocks acceptance in IDLE only.
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      raise(3'b011);
      cycle();
      chk("gate_ready", 32'(last_ready), 32'(0));
    end
    drain_start = 1'b1;
    cycle();
    chk("gate_start_ready", 32'(last_ready), 32'(0));
    chk("drain_busy_rise", 32'(drain_busy), 32'(1));
    cycle();
    chk("drain_grant", 32'(last_ready), 32'(3'b001));

    // Drain timing with source 1 active for 3 more cycles, plus an ignored drain_start.
    for (int k = 0; k < 3; k++) begin
      raise(3'b010);
      cycle();
    end
    flush();
    for (int k = 1; k <= Q; k++) begin
      if (k == 2) drain_start = 1'b1;
      cycle();
      chk("drain_done_pulse", 32'(drain_done), 32'(k == Q));
    end
    cycle();
    chk("drain_idle_busy", 32'(drain_busy), 32'(0));
    chk("drain_idle_done", 32'(drain_done), 32'(0));

    // Saturation and clear-with-transfer.
    enable = 1'b1;
    count_clear = 1'b1;
    cycle();
    for (int k = 0; k < 5; k++) begin
      raise(3'b100);
      cycle();
    end
    chk("sat_count", 32'(drop_count), 32'(CMAX));
    raise(3'b001);
    count_clear = 1'b1;
    cycle();
    chk("clear_xfer", 32'(drop_count), 32'(1));

    // Asynchronous reset in the middle of a drain.
    drain_start = 1'b1;
    cycle();
    cycle();
    chk("pre_rst_busy", 32'(drain_busy), 32'(1));
    raise(3'b001);
    apply_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'(0));
    chk("mid_rst_busy", 32'(drain_busy), 32'(0));
    chk("mid_rst_done", 32'(drain_done), 32'(0));
    chk("mid_rst_count", 32'(drop_count), 32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    raise('1);
    cycle();
    chk("post_rst_grant", 32'(last_ready), 32'(3'b001));
    flush();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      enable      = ($urandom_range(0, 3) != 0);
      drain_start = ($urandom_range(0, 19) == 0);
      count_clear = ($urandom_range(0, 15) == 0);
      raise(N'($urandom) & N'($urandom));
      cycle();
    end
    enable = 1'b1;
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
